// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared types and defaults for the UART transmit arbiter.
//   - arb_state_t : arbiter FSM states
//   - DATA_W_DEF  : default byte width
package uart_tx_arbiter_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick
//   Combinational round-robin priority encoder. Returns the first set
//   request scanning i_ptr, i_ptr+1, ... modulo N.
//   Ports:
//     i_req [N]  : request vector
//     i_ptr [PW] : highest-priority index this cycle
//     o_idx [PW] : winning index (0 when nothing is requested)
//     o_any      : at least one request is set
module uart_tx_arbiter_rr_pick #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int w_k;

  // Walk offsets from farthest to nearest so the nearest valid request
  // to the pointer is the last assignment and therefore wins.
  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    w_k   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = (int'(i_ptr) + i) % N;
      if (i_req[w_k]) o_idx = PW'(w_k);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ byte sources with
//   round-robin selection, a one-byte holding register and a start/busy
//   handshake guarded by a timeout.
//   Ports:
//     i_clk, i_reset (async, active low)
//     i_req_valid [N_REQ], i_req_data [N_REQ*DATA_W], o_req_ready [N_REQ]
//     o_tx_data [DATA_W], o_tx_start, i_tx_busy   : transmitter handshake
//     o_grant_id, o_active, o_timeout_err, o_byte_count : status
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int DATA_W       = DATA_W_DEF,
  parameter  int BUSY_TIMEOUT = 16,
  parameter  int CNT_W        = 16,
  localparam int GW           = $clog2(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]       o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_busy,
  output logic [GW-1:0]           o_grant_id,
  output logic                    o_active,
  output logic                    o_timeout_err,
  output logic [CNT_W-1:0]        o_byte_count
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t        r_state;
  logic [GW-1:0]     r_rr_ptr;
  logic [TW-1:0]     r_to_cnt;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_start;
  logic [GW-1:0]     r_grant_id;
  logic              r_active;
  logic              r_timeout_err;
  logic [CNT_W-1:0]  r_byte_count;

  logic [GW-1:0]     w_win;
  logic              w_any;
  logic              w_accept;
  logic [GW-1:0]     w_next_ptr;
  logic [DATA_W-1:0] w_win_data;

  uart_tx_arbiter_rr_pick #(.N(N_REQ)) u_pick (
    .i_req (i_req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  // Foreign traffic on the line (busy while idle) blocks acceptance.
  assign w_accept   = (r_state == IDLE) && !i_tx_busy && w_any;
  assign w_next_ptr = (w_win == GW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_win_data = i_req_data[int'(w_win)*DATA_W +: DATA_W];

  // Ready is a same-cycle strobe; gated by reset so nothing is accepted
  // while the arbiter is held.
  assign o_req_ready = (w_accept && i_reset) ? (N_REQ'(1) << w_win) : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_to_cnt      <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_grant_id    <= '0;
      r_active      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_byte_count  <= '0;
    end else begin
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tx_data  <= w_win_data;
            r_grant_id <= w_win;
            r_rr_ptr   <= w_next_ptr;
            r_active   <= 1'b1;
            r_tx_start <= 1'b1;   // visible during ISSUE
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_tx_busy) begin
            r_byte_count <= r_byte_count + 1'b1;
            r_state      <= WAIT_DONE;
          end else if (r_to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
            // Byte is dropped; pointer already moved past this requester.
            r_timeout_err <= 1'b1;
            r_active      <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            r_active <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_grant_id    = r_grant_id;
  assign o_active      = r_active;
  assign o_timeout_err = r_timeout_err;
  assign o_byte_count  = r_byte_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter with a simple transmitter model
//   (busy rises two cycles after start and stays high for ten cycles).
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            active;
  logic            timeout_err;
  logic [CW-1:0]   byte_count;

  logic mbusy = 1'b0, ext_busy = 1'b0, model_en = 1'b1;
  assign tx_busy = mbusy | ext_busy;

  int n_chk = 0, n_fail = 0;
  int exp_cnt = 0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .BUSY_TIMEOUT(TO), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_busy(tx_busy), .o_grant_id(grant_id), .o_active(active),
    .o_timeout_err(timeout_err), .o_byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Transmitter model
  initial forever begin
    @(negedge clk);
    if (model_en && tx_start) begin
      @(negedge clk);
      @(negedge clk);
      mbusy = 1'b1;
      repeat (10) @(negedge clk);
      mbusy = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_start) begin seen = 1'b1; break; end
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!active) begin seen = 1'b1; break; end
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  logic [7:0] exp_seq [0:4];
  logic [1:0] exp_gnt [0:4];

  initial begin
    int k;
    bit any_rdy;

    // --- reset state, single byte from requester 0 ---
    req_valid = 4'b0001;
    req_data[7:0] = 8'h41;
    tick(); tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_active", active, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_count", byte_count, 0);
    rst_n = 1'b1;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'h41);
    chk("t1_grant", grant_id, 0);
    chk("t1_active", active, 1);
    chk("t1_ready_off", req_ready, 0);
    req_valid = '0;
    wait_idle("t1_idle_bound");
    exp_cnt++;
    chk("t1_busy_low", tx_busy, 0);
    chk("t1_count", byte_count, exp_cnt);

    // --- round robin with all requesters valid ---
    pulse_reset();
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    exp_seq[0] = 8'h10; exp_seq[1] = 8'h20; exp_seq[2] = 8'h30;
    exp_seq[3] = 8'h40; exp_seq[4] = 8'h10;
    exp_gnt[0] = 2'd0; exp_gnt[1] = 2'd1; exp_gnt[2] = 2'd2;
    exp_gnt[3] = 2'd3; exp_gnt[4] = 2'd0;
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_start("rr_start_bound");
      chk("rr_data", tx_data, exp_seq[f]);
      chk("rr_grant", grant_id, exp_gnt[f]);
      exp_cnt++;
    end
    req_valid = '0;
    wait_idle("rr_idle_bound");
    chk("rr_count", byte_count, exp_cnt);

    // --- timeout: transmitter never answers ---
    model_en = 1'b0;
    req_valid = 4'b0110;
    wait_start("to_start_bound");
    chk("to_grant", grant_id, 1);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      k++;
      if (timeout_err) break;
    end
    chk("to_delay", k, 17);
    chk("to_no_start", tx_start, 0);
    chk("to_active", active, 0);
    chk("to_count", byte_count, exp_cnt);
    chk("to_next_ready", req_ready, 4'b0100);
    model_en = 1'b1;
    tick();
    chk("to_next_start", tx_start, 1);
    chk("to_next_grant", grant_id, 2);
    chk("to_next_data", tx_data, 8'h30);
    chk("to_err_pulse", timeout_err, 0);
    req_valid = '0;
    wait_idle("to_idle_bound");
    exp_cnt++;

    // --- foreign busy blocks acceptance ---
    ext_busy = 1'b1;
    req_valid = 4'b0010;
    any_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (req_ready != 0) any_rdy = 1'b1;
    end
    chk("fb_blocked", any_rdy, 0);
    ext_busy = 1'b0;
    #1;
    chk("fb_ready", req_ready, 4'b0010);
    tick();
    chk("fb_start", tx_start, 1);
    chk("fb_grant", grant_id, 1);
    req_valid = '0;
    wait_idle("fb_idle_bound");
    exp_cnt++;
    chk("fb_count", byte_count, exp_cnt);

    // --- async reset during WAIT_DONE ---
    req_valid = 4'b0010;
    wait_start("ar_start_bound");
    req_valid = '0;
    repeat (4) tick();
    chk("ar_busy_phase", active, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_active", active, 0);
    chk("ar_count", byte_count, 0);
    chk("ar_grant", grant_id, 0);
    chk("ar_data", tx_data, 0);
    chk("ar_start", tx_start, 0);
    for (int i = 0; i < 30; i++) begin
      if (!tx_busy) break;
      tick();
    end
    chk("ar_model_idle", tx_busy, 0);
    req_data[7:0]   = 8'hA0;
    req_data[23:16] = 8'hC2;
    req_valid = 4'b0101;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    #1;
    chk("ar_ready", req_ready, 4'b0001);
    tick();
    chk("ar_grant0", grant_id, 0);
    chk("ar_data0", tx_data, 8'hA0);
    req_valid = '0;
    wait_idle("ar_idle_bound");
    exp_cnt++;
    chk("ar_count1", byte_count, exp_cnt);

    // --- byte counter wrap with CNT_W=4 ---
    pulse_reset();
    req_valid = 4'b0001;
    for (int f = 0; f < 17; f++) wait_start("wr_start_bound");
    req_valid = '0;
    wait_idle("wr_idle_bound");
    chk("wr_count", byte_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between N_REQ byte sources: switch push on btnC, echo of received bytes, VGA/status reporter and a spare.
- Sits between the requesters and the transmitter's start/busy interface.
- Uses round-robin selection, a one-byte holding register and a start/busy handshake with timeout.
- Exports grant and byte-count status for the seven-segment display.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- BUSY_TIMEOUT, 16, cycles allowed between tx_start and tx_busy rising.
- CNT_W, 16, width of the sent-byte counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  N_REQ  per-requester byte-available.
- req_data  in  N_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  accept strobe; transfer occurs when valid&ready.
- tx_data  out  DATA_W  byte presented to the transmitter.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_busy  in  1  transmitter busy (high from frame start to stop bit end).
- grant_id  out  $clog2(N_REQ)  index of the last accepted requester.
- active  out  1  high from accept until the transmitter releases busy.
- timeout_err  out  1  one-cycle pulse when busy fails to rise.
- byte_count  out  CNT_W  bytes successfully started; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, tx_data=0, tx_start=0, grant_id=0, active=0, timeout_err=0, byte_count=0, req_ready=0. Reset asserted mid-frame aborts immediately; the transmitter's own frame is not the arbiter's concern.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE
  - If tx_busy=0 and any req_valid: winner = first valid index scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready[winner]=1 combinationally in this cycle only; req_ready is 0 in all other states.
  - On the accept edge: tx_data<=req_data[winner], grant_id<=winner, rr_ptr<=(winner+1) mod N_REQ, active<=1, go ISSUE.
  - If tx_busy=1 in IDLE (foreign traffic), nothing is accepted.
- ISSUE: tx_start=1 for exactly this cycle; clear timeout counter; go WAIT_BUSY.
- WAIT_BUSY
  - tx_busy=1 -> byte_count+=1, go WAIT_DONE.
  - Otherwise the counter increments; when it reaches BUSY_TIMEOUT: timeout_err pulses 1 cycle, active<=0, go IDLE. The byte is dropped and not retried; rr_ptr stays advanced.
- WAIT_DONE: tx_busy=0 -> active<=0, go IDLE.
- Latency:
  - accept at cycle T, tx_start at T+1.
  - Earliest next accept is the cycle after tx_busy is sampled low in WAIT_DONE.
- tx_data is held stable from the accept edge until the next accept.
- A requester dropping valid before being granted loses nothing; the arbiter never samples ungranted data.
- Simultaneous requests are served one per frame in round-robin order. With all N_REQ valid continuously, each requester is served once every N_REQ frames (no starvation).
- byte_count wraps from 2^CNT_W-1 to 0.
- timeout_err and tx_start are never high in the same cycle.

Decomposition:
- Shared package holds the FSM state typedef (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE) and the default DATA_W=8.
- One sub-module: rr_pick (combinational round-robin priority encoder: req vector + pointer -> winner index + any flag), reusable by other shared-resource arbiters.

Test Plan:
- Reset release, req_valid=0001, data0=0x41; model busy rises 2 cycles after start for 10 cycles -> req_ready[0] one cycle, tx_start next cycle with tx_data=0x41, byte_count=1, active falls after busy falls.
- req_valid=1111 held, data=0x10/0x20/0x30/0x40 -> transmitted order 0x10,0x20,0x30,0x40,0x10; grant_id 0,1,2,3,0.
- Transmitter never raises busy, BUSY_TIMEOUT=16 -> timeout_err pulse exactly 17 cycles after tx_start, byte_count unchanged, FSM back to IDLE, next requester accepted.
- tx_busy=1 held externally while req_valid=0010 -> req_ready stays 0; busy drops -> accept within 1 cycle.
- Reset asserted during WAIT_DONE -> all outputs 0 asynchronously; after release, rr_ptr=0 so requester 0 wins over 2 when both valid.
- CNT_W=4, 17 successful frames -> byte_count reads 1 (wrap).
